// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_ctrl
// Purpose : Pipeline sequencing controller for a 3-stage RV32I core
//           (IF / ID / EX). Drives PC, if_id and id_ex hold/flush controls.
//           Owns the data-RAM read handshake for loads decoded in ID, and
//           resolves load-use hazards, slow RAM reads and EX redirects.
//           Also keeps a saturating stall-cycle counter.
// Ports   :
//   clk, rst                 clock, asynchronous active-low reset
//   id_mem_rd_req_i/addr_i   load request and address from ID
//   id_rd/rs1/rs2_addr_i     register indices of the ID instruction
//   mem_rd_ready_i           RAM read data valid
//   jump_en_i/jump_addr_i    EX redirect request and target
//   mem_rd_req_o/addr_o      read request to RAM
//   hold_*_o, flush_*_o      pipeline register controls
//   jump_en_o/jump_addr_o    PC redirect
//   ld_timeout_o             one-cycle pulse when a stuck load is aborted
//   stall_cnt_o              saturating count of cycles with hold_pc_o=1
// Revision: 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_mem_rd_req_i,
  input  logic [31:0]      id_mem_rd_addr_i,
  input  logic [4:0]       id_rd_addr_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             mem_rd_ready_i,
  input  logic             jump_en_i,
  input  logic [31:0]      jump_addr_i,
  output logic             mem_rd_req_o,
  output logic [31:0]      mem_rd_addr_o,
  output logic             hold_pc_o,
  output logic             hold_if_id_o,
  output logic             hold_id_ex_o,
  output logic             flush_if_id_o,
  output logic             flush_id_ex_o,
  output logic             jump_en_o,
  output logic [31:0]      jump_addr_o,
  output logic             ld_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int c_WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LD_WAIT = 2'd1,
    LD_USE  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [4:0]          r_ld_rd, w_ld_rd_nxt;
  logic [4:0]          r_rd, w_rd_nxt;
  logic [31:0]         r_addr, w_addr_nxt;
  logic [c_WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic        w_req, w_hold_pc, w_hold_if_id, w_hold_id_ex;
  logic        w_flush_if_id, w_flush_id_ex, w_jump_en, w_timeout;
  logic [31:0] w_maddr, w_jaddr;
  logic        w_take_load;
  logic        w_hit;

  assign w_hit = (r_ld_rd != 5'd0) &&
                 ((id_rs1_addr_i == r_ld_rd) || (id_rs2_addr_i == r_ld_rd));

  always_comb begin
    w_req         = 1'b0;
    w_maddr       = 32'd0;
    w_hold_pc     = 1'b0;
    w_hold_if_id  = 1'b0;
    w_hold_id_ex  = 1'b0;
    w_flush_if_id = 1'b0;
    w_flush_id_ex = 1'b0;
    w_jump_en     = 1'b0;
    w_jaddr       = 32'd0;
    w_timeout     = 1'b0;
    w_take_load   = 1'b0;
    w_state_nxt   = r_state;
    w_ld_rd_nxt   = r_ld_rd;
    w_rd_nxt      = r_rd;
    w_addr_nxt    = r_addr;
    w_wait_nxt    = r_wait_cnt;

    if (jump_en_i) begin
      // Redirect cancels any pending load or bubble.
      w_jump_en     = 1'b1;
      w_jaddr       = jump_addr_i;
      w_flush_if_id = 1'b1;
      w_flush_id_ex = 1'b1;
      w_state_nxt   = RUN;
      w_ld_rd_nxt   = 5'd0;
      w_wait_nxt    = '0;
    end else begin
      case (r_state)
        RUN: begin
          w_take_load = id_mem_rd_req_i;
        end
        LD_WAIT: begin
          // Address comes from the latched copy so it stays stable even
          // if ID presents something else while held.
          w_req   = 1'b1;
          w_maddr = r_addr;
          if (mem_rd_ready_i) begin
            w_ld_rd_nxt = r_rd;
            w_state_nxt = (r_rd != 5'd0) ? LD_USE : RUN;
            w_wait_nxt  = '0;
          end else if (r_wait_cnt == c_WAIT_W'(TIMEOUT)) begin
            w_timeout     = 1'b1;
            w_flush_id_ex = 1'b1;
            w_state_nxt   = RUN;
            w_wait_nxt    = '0;
          end else begin
            w_hold_pc    = 1'b1;
            w_hold_if_id = 1'b1;
            w_hold_id_ex = 1'b1;
            w_wait_nxt   = r_wait_cnt + c_WAIT_W'(1);
          end
        end
        LD_USE: begin
          w_state_nxt = RUN;
          w_ld_rd_nxt = 5'd0;
          if (w_hit) begin
            // One bubble; a load sitting in ID is re-presented next cycle.
            w_hold_pc     = 1'b1;
            w_hold_if_id  = 1'b1;
            w_flush_id_ex = 1'b1;
          end else begin
            w_take_load = id_mem_rd_req_i;
          end
        end
        default: begin
          w_state_nxt = RUN;
          w_ld_rd_nxt = 5'd0;
        end
      endcase

      if (w_take_load) begin
        w_req   = 1'b1;
        w_maddr = id_mem_rd_addr_i;
        if (mem_rd_ready_i) begin
          w_ld_rd_nxt = id_rd_addr_i;
          w_state_nxt = (id_rd_addr_i != 5'd0) ? LD_USE : RUN;
        end else begin
          w_hold_pc    = 1'b1;
          w_hold_if_id = 1'b1;
          w_hold_id_ex = 1'b1;
          w_addr_nxt   = id_mem_rd_addr_i;
          w_rd_nxt     = id_rd_addr_i;
          w_wait_nxt   = c_WAIT_W'(1);
          w_state_nxt  = LD_WAIT;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_ld_rd     <= 5'd0;
      r_rd        <= 5'd0;
      r_addr      <= 32'd0;
      r_wait_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ld_rd    <= w_ld_rd_nxt;
      r_rd       <= w_rd_nxt;
      r_addr     <= w_addr_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_hold_pc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  // Outputs are forced low while reset is asserted, whatever the inputs do.
  assign mem_rd_req_o  = rst & w_req;
  assign mem_rd_addr_o = rst ? w_maddr : 32'd0;
  assign hold_pc_o     = rst & w_hold_pc;
  assign hold_if_id_o  = rst & w_hold_if_id;
  assign hold_id_ex_o  = rst & w_hold_id_ex;
  assign flush_if_id_o = rst & w_flush_if_id;
  assign flush_id_ex_o = rst & w_flush_id_ex;
  assign jump_en_o     = rst & w_jump_en;
  assign jump_addr_o   = rst ? w_jaddr : 32'd0;
  assign ld_timeout_o  = rst & w_timeout;
  assign stall_cnt_o   = r_stall_cnt;

endmodule
`default_nettype wire
